// File: rtl/hazard_ctrl.sv
// Decode-side hazard scheduler: operand forwarding, load-use stall, jump flush and
// multi-cycle memory wait sequencing. Optional perf counters under HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             ex_wb_en_i,
  input  logic [4:0]       ex_wb_addr_i,
  input  logic             ex_is_load_i,
  input  logic             wb_wb_en_i,
  input  logic [4:0]       wb_wb_addr_i,
  input  logic             jump_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             ex_stall_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             mem_timeout_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt_o,
  output logic [CNT_W-1:0] perf_flush_cnt_o
`endif
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_MEM_WAIT} state_e;

  state_e           state_q, state_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             jump_pend_q, jump_pend_d;
  logic [1:0]       hold_a_q, hold_a_d, hold_b_q, hold_b_d;

  logic [1:0] fwd_a_raw, fwd_b_raw, fwd_a_c, fwd_b_c;
  logic       load_use, mem_busy, tmo_hit;
  logic       pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_bubble_c, ex_stall_c, tmo_c;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic ex_en,
                                         input logic [4:0] ex_rd, input logic ex_ld,
                                         input logic wb_en, input logic [4:0] wb_rd);
    if (ex_en && !ex_ld && rs != 5'd0 && ex_rd == rs) return 2'b01;
    else if (wb_en && rs != 5'd0 && wb_rd == rs)     return 2'b10;
    else                                             return 2'b00;
  endfunction

  assign fwd_a_raw = fwd_sel(id_rs1_addr_i, ex_wb_en_i, ex_wb_addr_i, ex_is_load_i,
                             wb_wb_en_i, wb_wb_addr_i);
  assign fwd_b_raw = fwd_sel(id_rs2_addr_i, ex_wb_en_i, ex_wb_addr_i, ex_is_load_i,
                             wb_wb_en_i, wb_wb_addr_i);

  assign load_use = id_valid_i && ex_is_load_i && ex_wb_en_i && (ex_wb_addr_i != 5'd0) &&
                    ((id_use_rs1_i && id_rs1_addr_i == ex_wb_addr_i) ||
                     (id_use_rs2_i && id_rs2_addr_i == ex_wb_addr_i));
  assign mem_busy = mem_req_i && !mem_ack_i;
  assign tmo_hit  = (state_q == ST_MEM_WAIT) && !mem_ack_i && (tmo_q == TMO_LAST);

  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    tmo_d          = tmo_q;
    jump_pend_d    = jump_pend_q;
    hold_a_d       = fwd_a_raw;
    hold_b_d       = fwd_b_raw;
    fwd_a_c        = fwd_a_raw;
    fwd_b_c        = fwd_b_raw;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_bubble_c = 1'b0;
    ex_stall_c     = 1'b0;
    tmo_c          = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          ex_stall_c    = 1'b1;
          state_d       = ST_MEM_WAIT;
          tmo_d         = '0;
          jump_pend_d   = jump_taken_i;
        end else if (jump_taken_i) begin
          if_id_flush_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            fcnt_d  = 2'(FLUSH_CYCLES - 1);
          end
        end else if (load_use) begin
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
        end
      end
      ST_FLUSH: begin
        if_id_flush_c  = 1'b1;
        id_ex_bubble_c = 1'b1;
        if (jump_taken_i) begin
          fcnt_d = 2'(FLUSH_CYCLES - 1);
        end else if (fcnt_q == 2'd1) begin
          fcnt_d  = 2'd0;
          state_d = ST_RUN;
        end else begin
          fcnt_d = fcnt_q - 2'd1;
        end
      end
      ST_MEM_WAIT: begin
        // Forward selects stay as captured when the access started.
        fwd_a_c  = hold_a_q;
        fwd_b_c  = hold_b_q;
        hold_a_d = hold_a_q;
        hold_b_d = hold_b_q;
        if (!mem_ack_i) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          ex_stall_c    = 1'b1;
          tmo_d         = tmo_q + 1'b1;
        end
        tmo_c = tmo_hit;
        // A timeout is treated as completion, including release of a pending jump.
        if (mem_ack_i || tmo_hit) begin
          tmo_d       = '0;
          jump_pend_d = 1'b0;
          if (jump_pend_q) begin
            state_d = ST_FLUSH;
            fcnt_d  = 2'(FLUSH_CYCLES);
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      fcnt_q      <= '0;
      tmo_q       <= '0;
      jump_pend_q <= 1'b0;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      tmo_q       <= tmo_d;
      jump_pend_q <= jump_pend_d;
      hold_a_q    <= hold_a_d;
      hold_b_q    <= hold_b_d;
    end
  end

  // Outputs are combinational, so they are forced low while reset is held.
  assign pc_stall_o     = rst_n & pc_stall_c;
  assign if_id_stall_o  = rst_n & if_id_stall_c;
  assign if_id_flush_o  = rst_n & if_id_flush_c;
  assign id_ex_bubble_o = rst_n & id_ex_bubble_c;
  assign ex_stall_o     = rst_n & ex_stall_c;
  assign fwd_a_o        = {2{rst_n}} & fwd_a_c;
  assign fwd_b_o        = {2{rst_n}} & fwd_b_c;
  assign mem_timeout_o  = rst_n & tmo_c;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             jump_accept;

  assign jump_accept = ((state_q == ST_RUN) && !mem_busy && jump_taken_i) ||
                       ((state_q == ST_FLUSH) && jump_taken_i) ||
                       ((state_q == ST_MEM_WAIT) && (mem_ack_i || tmo_hit) && jump_pend_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall_c)  stall_cnt_q <= stall_cnt_q + 1'b1;
      if (jump_accept) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with constant expectations, then
// randomized traffic against a cycle-level behavioural model of the scheduler.
module tb_hazard_ctrl;
  localparam int FC = 2;
  localparam int MT = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid_i, id_use_rs1_i, id_use_rs2_i;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_wb_addr_i, wb_wb_addr_i;
  logic ex_wb_en_i, ex_is_load_i, wb_wb_en_i, jump_taken_i, mem_req_i, mem_ack_i;
  logic pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o, ex_stall_o, mem_timeout_o;
  logic [1:0] fwd_a_o, fwd_b_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: remaining flush cycles, outstanding access and its age.
  int         m_flush_left;
  bit         m_in_mem;
  int         m_req_age;
  bit         m_jpend;
  logic [1:0] m_hold_a, m_hold_b;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .ex_wb_en_i(ex_wb_en_i), .ex_wb_addr_i(ex_wb_addr_i), .ex_is_load_i(ex_is_load_i),
    .wb_wb_en_i(wb_wb_en_i), .wb_wb_addr_i(wb_wb_addr_i),
    .jump_taken_i(jump_taken_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o), .if_id_flush_o(if_id_flush_o),
    .id_ex_bubble_o(id_ex_bubble_o), .ex_stall_o(ex_stall_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .mem_timeout_o(mem_timeout_o)
  );

  // {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_stall, fwd_a, fwd_b, mem_timeout}
  function automatic logic [9:0] outs();
    return {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o, ex_stall_o,
            fwd_a_o, fwd_b_o, mem_timeout_o};
  endfunction

  task automatic idle();
    id_valid_i = 0; id_use_rs1_i = 0; id_use_rs2_i = 0;
    id_rs1_addr_i = 0; id_rs2_addr_i = 0; ex_wb_addr_i = 0; wb_wb_addr_i = 0;
    ex_wb_en_i = 0; ex_is_load_i = 0; wb_wb_en_i = 0;
    jump_taken_i = 0; mem_req_i = 0; mem_ack_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_flush_left = 0; m_in_mem = 0; m_req_age = 0; m_jpend = 0;
    m_hold_a = 0; m_hold_b = 0;
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rs == 0) return 2'b00;
    if (ex_wb_en_i && !ex_is_load_i && ex_wb_addr_i == rs) return 2'b01;
    if (wb_wb_en_i && wb_wb_addr_i == rs) return 2'b10;
    return 2'b00;
  endfunction

  // Expected outputs for this cycle's inputs; advances the model to the next cycle.
  task automatic model_step(output logic [9:0] exp);
    logic [1:0] a, b, fa, fb;
    logic pc, ifid, fl, bub, exs, tmo, lu;
    a = ref_fwd(id_rs1_addr_i);
    b = ref_fwd(id_rs2_addr_i);
    fa = a; fb = b;
    {pc, ifid, fl, bub, exs, tmo} = 6'b0;
    lu = id_valid_i && ex_is_load_i && ex_wb_en_i && ex_wb_addr_i != 0 &&
         ((id_use_rs1_i && id_rs1_addr_i == ex_wb_addr_i) ||
          (id_use_rs2_i && id_rs2_addr_i == ex_wb_addr_i));
    if (m_in_mem) begin
      fa = m_hold_a; fb = m_hold_b;
      m_req_age++;
      if (!mem_ack_i) {pc, ifid, exs} = 3'b111;
      if (mem_ack_i || m_req_age == MT) begin
        tmo = !mem_ack_i;
        m_in_mem = 0;
        if (m_jpend) m_flush_left = FC;
        m_jpend = 0;
      end
    end else if (m_flush_left > 0) begin
      fl = 1; bub = 1;
      m_flush_left = jump_taken_i ? FC - 1 : m_flush_left - 1;
    end else if (mem_req_i && !mem_ack_i) begin
      {pc, ifid, exs} = 3'b111;
      m_in_mem = 1; m_req_age = 0; m_jpend = jump_taken_i;
      m_hold_a = a; m_hold_b = b;
    end else if (jump_taken_i) begin
      fl = 1; bub = 1;
      m_flush_left = FC - 1;
    end else if (lu) begin
      pc = 1; ifid = 1; bub = 1;
    end
    exp = {pc, ifid, fl, bub, exs, fa, fb, tmo};
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    jump_taken_i = 1; mem_req_i = 1; ex_wb_en_i = 1; ex_wb_addr_i = 3;
    id_rs1_addr_i = 3; wb_wb_en_i = 1; wb_wb_addr_i = 3;
    #2;
    n_checks++;
    if (outs() !== 10'b0) begin n_fail++; $display("FAIL reset_hold: got %b want %b", outs(), 10'b0); end
    else $display("ok reset_hold outs=%b", outs());
    tick(); tick();
    idle();
    rst_n = 1;
    #2;
    n_checks++;
    if (outs() !== 10'b0) begin n_fail++; $display("FAIL reset_release: got %b want %b", outs(), 10'b0); end
    else $display("ok reset_release outs=%b", outs());
    tick();
  endtask

  task automatic test_load_use();
    idle();
    id_valid_i = 1; id_rs1_addr_i = 5; id_rs2_addr_i = 1; id_use_rs1_i = 1; id_use_rs2_i = 1;
    ex_wb_en_i = 1; ex_wb_addr_i = 5; ex_is_load_i = 1;
    #2;
    n_checks++;
    if (outs() !== 10'b11010_00_00_0) begin n_fail++; $display("FAIL load_use_stall: got %b want %b", outs(), 10'b11010_00_00_0); end
    else $display("ok load_use_stall outs=%b", outs());
    tick();
    ex_wb_en_i = 0; ex_is_load_i = 0; ex_wb_addr_i = 0; wb_wb_en_i = 1; wb_wb_addr_i = 5;
    #2;
    n_checks++;
    if (outs() !== 10'b00000_10_00_0) begin n_fail++; $display("FAIL load_use_wb_fwd: got %b want %b", outs(), 10'b00000_10_00_0); end
    else $display("ok load_use_wb_fwd outs=%b", outs());
    tick();
  endtask

  task automatic test_forwarding();
    idle();
    id_valid_i = 1; id_rs1_addr_i = 3; id_rs2_addr_i = 3; id_use_rs1_i = 1; id_use_rs2_i = 1;
    ex_wb_en_i = 1; ex_wb_addr_i = 3; wb_wb_en_i = 1; wb_wb_addr_i = 3;
    #2;
    n_checks++;
    if (outs() !== 10'b00000_01_01_0) begin n_fail++; $display("FAIL fwd_ex_over_wb: got %b want %b", outs(), 10'b00000_01_01_0); end
    else $display("ok fwd_ex_over_wb outs=%b", outs());
    id_rs1_addr_i = 0; id_rs2_addr_i = 0; ex_wb_addr_i = 0; wb_wb_addr_i = 0;
    #1;
    n_checks++;
    if (outs() !== 10'b0) begin n_fail++; $display("FAIL fwd_x0: got %b want %b", outs(), 10'b0); end
    else $display("ok fwd_x0 outs=%b", outs());
    id_rs1_addr_i = 9; id_rs2_addr_i = 4; ex_wb_addr_i = 7; wb_wb_addr_i = 9;
    #1;
    n_checks++;
    if (outs() !== 10'b00000_10_00_0) begin n_fail++; $display("FAIL fwd_wb_only: got %b want %b", outs(), 10'b00000_10_00_0); end
    else $display("ok fwd_wb_only outs=%b", outs());
    tick();
  endtask

  task automatic test_jump_flush();
    idle();
    jump_taken_i = 1;
    #2;
    n_checks++;
    if (outs() !== 10'b00110_00_00_0) begin n_fail++; $display("FAIL jump_c0: got %b want %b", outs(), 10'b00110_00_00_0); end
    else $display("ok jump_c0 outs=%b", outs());
    tick();
    jump_taken_i = 0;
    id_valid_i = 1; id_rs1_addr_i = 6; id_use_rs1_i = 1;
    ex_wb_en_i = 1; ex_wb_addr_i = 6; ex_is_load_i = 1;
    #2;
    n_checks++;
    if (outs() !== 10'b00110_00_00_0) begin n_fail++; $display("FAIL jump_c1_no_lu: got %b want %b", outs(), 10'b00110_00_00_0); end
    else $display("ok jump_c1_no_lu outs=%b", outs());
    tick();
    idle();
    #2;
    n_checks++;
    if (outs() !== 10'b0) begin n_fail++; $display("FAIL jump_done: got %b want %b", outs(), 10'b0); end
    else $display("ok jump_done outs=%b", outs());
    tick();
  endtask

  task automatic test_mem_wait();
    idle();
    mem_req_i = 1; id_rs1_addr_i = 3; ex_wb_en_i = 1; ex_wb_addr_i = 3;
    #2;
    n_checks++;
    if (outs() !== 10'b11001_01_00_0) begin n_fail++; $display("FAIL mem_c0: got %b want %b", outs(), 10'b11001_01_00_0); end
    else $display("ok mem_c0 outs=%b", outs());
    tick();
    idle();
    for (int c = 1; c <= 4; c++) begin
      #2;
      n_checks++;
      if (outs() !== 10'b11001_01_00_0) begin n_fail++; $display("FAIL mem_wait_c%0d: got %b want %b", c, outs(), 10'b11001_01_00_0); end
      else $display("ok mem_wait_c%0d outs=%b", c, outs());
      tick();
    end
    mem_ack_i = 1;
    #2;
    n_checks++;
    if (outs() !== 10'b00000_01_00_0) begin n_fail++; $display("FAIL mem_ack_release: got %b want %b", outs(), 10'b00000_01_00_0); end
    else $display("ok mem_ack_release outs=%b", outs());
    tick();
    mem_ack_i = 0;
    #2;
    n_checks++;
    if (outs() !== 10'b0) begin n_fail++; $display("FAIL mem_after: got %b want %b", outs(), 10'b0); end
    else $display("ok mem_after outs=%b", outs());
    tick();
  endtask

  task automatic test_mem_jump();
    logic [9:0] exp;
    idle();
    mem_req_i = 1; jump_taken_i = 1;
    for (int c = 0; c <= 6; c++) begin
      if (c == 1) idle();
      mem_ack_i = (c == 3);
      exp = (c < 3) ? 10'b11001_00_00_0 : (c == 4 || c == 5) ? 10'b00110_00_00_0 : 10'b0;
      #2;
      n_checks++;
      if (outs() !== exp) begin n_fail++; $display("FAIL mem_jump_c%0d: got %b want %b", c, outs(), exp); end
      else $display("ok mem_jump_c%0d outs=%b", c, outs());
      tick();
    end
    idle();
  endtask

  task automatic test_timeout_reset();
    logic [9:0] exp;
    idle();
    mem_req_i = 1;
    for (int c = 0; c <= 9; c++) begin
      if (c == 1) idle();
      exp = (c < 8) ? 10'b11001_00_00_0 : (c == 8) ? 10'b11001_00_00_1 : 10'b0;
      #2;
      n_checks++;
      if (outs() !== exp) begin n_fail++; $display("FAIL timeout_c%0d: got %b want %b", c, outs(), exp); end
      else $display("ok timeout_c%0d outs=%b", c, outs());
      tick();
    end
    jump_taken_i = 1;
    tick();
    jump_taken_i = 0;
    #2;
    n_checks++;
    if (outs() !== 10'b00110_00_00_0) begin n_fail++; $display("FAIL flush_before_reset: got %b want %b", outs(), 10'b00110_00_00_0); end
    else $display("ok flush_before_reset outs=%b", outs());
    rst_n = 0;
    jump_taken_i = 1; mem_req_i = 1; wb_wb_en_i = 1; wb_wb_addr_i = 2; id_rs1_addr_i = 2;
    #1;
    n_checks++;
    if (outs() !== 10'b0) begin n_fail++; $display("FAIL reset_mid_flush: got %b want %b", outs(), 10'b0); end
    else $display("ok reset_mid_flush outs=%b", outs());
    tick();
    idle();
    rst_n = 1;
    for (int c = 0; c < 2; c++) begin
      #2;
      n_checks++;
      if (outs() !== 10'b0) begin n_fail++; $display("FAIL no_flush_after_reset_c%0d: got %b want %b", c, outs(), 10'b0); end
      else $display("ok no_flush_after_reset_c%0d outs=%b", c, outs());
      tick();
    end
  endtask

  task automatic test_random();
    logic [9:0] exp;
    int errs;
    errs = 0;
    model_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc % 200 == 199) begin
        rst_n = 0;
        #2;
        n_checks++;
        if (outs() !== 10'b0) begin n_fail++; errs++; $display("FAIL rand_reset_cyc%0d: got %b want %b", cyc, outs(), 10'b0); end
        model_reset();
        tick();
        rst_n = 1;
      end
      id_valid_i    = 1'($urandom_range(0, 1));
      id_use_rs1_i  = 1'($urandom_range(0, 1));
      id_use_rs2_i  = 1'($urandom_range(0, 1));
      id_rs1_addr_i = 5'($urandom_range(0, 3));
      id_rs2_addr_i = 5'($urandom_range(0, 3));
      ex_wb_en_i    = 1'($urandom_range(0, 1));
      ex_wb_addr_i  = 5'($urandom_range(0, 3));
      ex_is_load_i  = 1'($urandom_range(0, 2) == 0);
      wb_wb_en_i    = 1'($urandom_range(0, 1));
      wb_wb_addr_i  = 5'($urandom_range(0, 3));
      jump_taken_i  = 1'($urandom_range(0, 7) == 0);
      mem_req_i     = 1'($urandom_range(0, 6) == 0);
      mem_ack_i     = 1'($urandom_range(0, 4) == 0);
      #2;
      model_step(exp);
      n_checks++;
      if (outs() !== exp) begin
        n_fail++; errs++;
        $display("FAIL rand_cyc%0d: got %b want %b", cyc, outs(), exp);
      end
      tick();
    end
    idle();
    $display("random segment: 800 cycles, %0d errors", errs);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_jump_flush();
    test_mem_wait();
    test_mem_jump();
    test_timeout_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
